// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//   N-core shared-bus arbiter with registered one-hot grants. Rotating
//   (round-robin) priority by default, legacy fixed priority when FIXED_PRIO=1.
//   An owner keeps the bus while its request stays high. Tenure is bounded by
//   MAX_HOLD whenever another core is waiting. Every change of owner passes
//   through one idle cycle.
//
// Handshake: request[i] is a level. Core i asks for the bus while it is high,
//   and keeps the bus while it is high and grant[i] is set. Dropping request[i]
//   while it owns the bus releases the bus at the next edge. A pending request
//   that drops before it is granted is simply forgotten.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   enable       gates new grants only (never removes an existing grant)
//   request      per-core request / hold level
//   grant        registered one-hot grant, zero when idle
//   grant_valid  registered OR of grant
//   grant_id     registered index of current owner (holds last value when idle)
//   preempted    one-cycle pulse on the cycle a grant is removed by tenure expiry
//   dbg_state    FSM state (0 = IDLE, 1 = OWNED)
//   dbg_prio_ptr current rotating-priority pointer
//   dbg_hold_cnt current tenure counter
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int NUM_CORES  = 4,
  parameter int MAX_HOLD   = 8,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int ID_W      = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_CORES-1:0] request,
  output logic [NUM_CORES-1:0] grant,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic                 preempted,
  output logic                 dbg_state,
  output logic [ID_W-1:0]      dbg_prio_ptr,
  output logic [7:0]           dbg_hold_cnt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 preempted_q, preempted_d;
  logic [ID_W-1:0]      prio_ptr_q, prio_ptr_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;

  // Arbitration decode
  logic [ID_W-1:0] winner;
  logic            found;
  logic [ID_W-1:0] scan_idx;
  int              scan_sum;
  logic            start_grant;
  logic            release_bus;
  logic            preempt_bus;
  logic            others_req;
  logic            tenure_done;
  logic [ID_W-1:0] owner_next;

  // First set request bit scanning upward from prio_ptr, wrapping.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    scan_sum = 0;
    for (int off = 0; off < NUM_CORES; off++) begin
      scan_sum = int'(prio_ptr_q) + off;
      if (scan_sum >= NUM_CORES) begin
        scan_sum = scan_sum - NUM_CORES;
      end
      scan_idx = ID_W'(scan_sum);
      if (!found && request[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    others_req  = |(request & ~grant_q);
    tenure_done = (hold_cnt_q == 8'(MAX_HOLD));
    start_grant = (state_q == ST_IDLE) && enable && found;
    // Release is checked first, so expiry coinciding with release is a release.
    release_bus = (state_q == ST_OWNED) && !request[grant_id_q];
    preempt_bus = (state_q == ST_OWNED) && !release_bus && tenure_done && others_req;
    owner_next  = (grant_id_q == ID_W'(NUM_CORES - 1)) ? '0 : grant_id_q + ID_W'(1);
  end

  // State register (all flops)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      preempted_q   <= 1'b0;
      prio_ptr_q    <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      preempted_q   <= preempted_d;
      prio_ptr_q    <= prio_ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_grant) state_d = ST_OWNED;
      ST_OWNED: if (release_bus || preempt_bus) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered-output / datapath next values
  always_comb begin
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    preempted_d   = 1'b0;
    prio_ptr_d    = prio_ptr_q;
    hold_cnt_d    = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
        if (start_grant) begin
          grant_d[winner] = 1'b1;
          grant_valid_d   = 1'b1;
          grant_id_d      = winner;
          hold_cnt_d      = 8'd1;
        end
      end
      ST_OWNED: begin
        if (release_bus || preempt_bus) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          preempted_d   = preempt_bus;
          // Legacy mode keeps core 0 on top forever.
          if (!FIXED_PRIO) begin
            prio_ptr_d = owner_next;
          end
        end else if (!tenure_done) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  assign grant        = grant_q;
  assign grant_valid  = grant_valid_q;
  assign grant_id     = grant_id_q;
  assign preempted    = preempted_q;
  assign dbg_state    = state_q;
  assign dbg_prio_ptr = prio_ptr_q;
  assign dbg_hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
//   Directed bench for bus_arbiter_rr: a round-robin instance (N=4, MAX_HOLD=4)
//   and a fixed-priority instance sharing clock, reset and enable.
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int MH = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  request;
  logic [N-1:0]  request_f;

  logic [N-1:0]  grant,        grant_f;
  logic          grant_valid,  grant_valid_f;
  logic [IW-1:0] grant_id,     grant_id_f;
  logic          preempted,    preempted_f;
  logic          dbg_state,    dbg_state_f;
  logic [IW-1:0] dbg_prio_ptr, dbg_prio_ptr_f;
  logic [7:0]    dbg_hold_cnt, dbg_hold_cnt_f;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.NUM_CORES(N), .MAX_HOLD(MH), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .reset(reset), .enable(enable), .request(request),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .preempted(preempted), .dbg_state(dbg_state),
    .dbg_prio_ptr(dbg_prio_ptr), .dbg_hold_cnt(dbg_hold_cnt)
  );

  bus_arbiter_rr #(.NUM_CORES(N), .MAX_HOLD(MH), .FIXED_PRIO(1'b1)) u_fx (
    .clk(clk), .reset(reset), .enable(enable), .request(request_f),
    .grant(grant_f), .grant_valid(grant_valid_f), .grant_id(grant_id_f),
    .preempted(preempted_f), .dbg_state(dbg_state_f),
    .dbg_prio_ptr(dbg_prio_ptr_f), .dbg_hold_cnt(dbg_hold_cnt_f)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b1;
    request   = '0;
    request_f = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0 || preempted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b valid=%b id=%0d pre=%b, required 0000/0/0/0",
               grant, grant_valid, grant_id, preempted);
    end
    n_cmp++;
    if (dbg_state !== 1'b0 || dbg_prio_ptr !== 2'd0 || dbg_hold_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_internal: state=%b ptr=%0d hold=%0d, required 0/0/0",
               dbg_state, dbg_prio_ptr, dbg_hold_cnt);
    end
    n_cmp++;
    if (grant_f !== 4'b0000 || grant_valid_f !== 1'b0 || grant_id_f !== 2'd0 || preempted_f !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fixed: grant=%b valid=%b id=%0d pre=%b, required 0000/0/0/0",
               grant_f, grant_valid_f, grant_id_f, preempted_f);
    end
  endtask

  // request=0011 held: core 0 for 4 cycles, preempt, core 1 for 4, preempt, core 0.
  task automatic test_preempt();
    logic [3:0]    exp_g [11];
    logic          exp_p [11];
    logic [IW-1:0] exp_i [11];
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
              4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    exp_p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_i = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    do_reset();
    request = 4'b0011;
    for (int k = 0; k < 11; k++) begin
      tick();
      n_cmp++;
      if (grant !== exp_g[k] || preempted !== exp_p[k] || grant_id !== exp_i[k] ||
          grant_valid !== (exp_g[k] != 4'b0000)) begin
        n_fail++;
        $display("FAIL preempt_seq[%0d]: grant=%b pre=%b id=%0d valid=%b, required %b/%b/%0d/%b",
                 k, grant, preempted, grant_id, grant_valid, exp_g[k], exp_p[k], exp_i[k],
                 exp_g[k] != 4'b0000);
      end
    end
    request = 4'b0000;
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || dbg_prio_ptr !== 2'd1) begin
      n_fail++;
      $display("FAIL preempt_release: grant=%b ptr=%0d, required 0000/1", grant, dbg_prio_ptr);
    end
  endtask

  // Lone requester never gets preempted; counter saturates.
  task automatic test_single_hold();
    do_reset();
    request = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (grant !== 4'b0100 || preempted !== 1'b0 || grant_id !== 2'd2) begin
        n_fail++;
        $display("FAIL single_hold[%0d]: grant=%b pre=%b id=%0d, required 0100/0/2",
                 k, grant, preempted, grant_id);
      end
    end
    n_cmp++;
    if (dbg_hold_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL hold_saturate: hold=%0d, required 4", dbg_hold_cnt);
    end
    request = 4'b0000;
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || dbg_prio_ptr !== 2'd3 || dbg_state !== 1'b0 || preempted !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: grant=%b ptr=%0d state=%b pre=%b, required 0000/3/0/0",
               grant, dbg_prio_ptr, dbg_state, preempted);
    end
  endtask

  // All four request; each owner releases after 2 cycles: 0,1,2,3,0 with one gap.
  task automatic test_round_robin();
    logic [3:0]    exp_oh;
    logic [IW-1:0] exp_ptr;
    do_reset();
    request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_oh  = 4'b0001 << (k % 4);
      exp_ptr = IW'((k + 1) % 4);
      for (int c = 0; c < 2; c++) begin
        tick();
        n_cmp++;
        if (grant !== exp_oh || grant_id !== IW'(k % 4) || preempted !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_grant[%0d.%0d]: grant=%b id=%0d pre=%b, required %b/%0d/0",
                   k, c, grant, grant_id, preempted, exp_oh, k % 4);
        end
      end
      if (k < 4) begin
        request[k % 4] = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || dbg_prio_ptr !== exp_ptr) begin
          n_fail++;
          $display("FAIL rr_gap[%0d]: grant=%b valid=%b ptr=%0d, required 0000/0/%0d",
                   k, grant, grant_valid, dbg_prio_ptr, exp_ptr);
        end
        request[k % 4] = 1'b1;
      end
    end
    request = 4'b0000;
  endtask

  // Legacy fixed priority: core 1 beats core 3 every time it is present.
  task automatic test_fixed_prio();
    do_reset();
    request_f = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (grant_f !== 4'b0010 || grant_id_f !== 2'd1) begin
        n_fail++;
        $display("FAIL fixed_first[%0d]: grant=%b id=%0d, required 0010/1", k, grant_f, grant_id_f);
      end
    end
    request_f = 4'b1000;
    tick();
    n_cmp++;
    if (grant_f !== 4'b0000 || dbg_prio_ptr_f !== 2'd0 || preempted_f !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_release: grant=%b ptr=%0d pre=%b, required 0000/0/0",
               grant_f, dbg_prio_ptr_f, preempted_f);
    end
    request_f = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (grant_f !== 4'b0010 || preempted_f !== 1'b0) begin
        n_fail++;
        $display("FAIL fixed_regrant[%0d]: grant=%b pre=%b, required 0010/0", k, grant_f, preempted_f);
      end
    end
    tick();
    n_cmp++;
    if (grant_f !== 4'b0000 || preempted_f !== 1'b1 || dbg_prio_ptr_f !== 2'd0) begin
      n_fail++;
      $display("FAIL fixed_preempt: grant=%b pre=%b ptr=%0d, required 0000/1/0",
               grant_f, preempted_f, dbg_prio_ptr_f);
    end
    tick();
    n_cmp++;
    if (grant_f !== 4'b0010 || preempted_f !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_after_preempt: grant=%b pre=%b, required 0010/0", grant_f, preempted_f);
    end
    request_f = 4'b0000;
  endtask

  task automatic test_enable();
    do_reset();
    enable  = 1'b0;
    request = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_off[%0d]: grant=%b valid=%b, required 0000/0", k, grant, grant_valid);
      end
    end
    enable = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_on: grant=%b valid=%b, required 0001/1", grant, grant_valid);
    end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (grant !== 4'b0001) begin
        n_fail++;
        $display("FAIL enable_drop_hold[%0d]: grant=%b, required 0001", k, grant);
      end
    end
    request = 4'b0000;
    tick();
    request = 4'b0001;
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_idle_after_release: grant=%b state=%b, required 0000/0", grant, dbg_state);
    end
    enable = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL enable_resume: grant=%b, required 0001", grant);
    end
    request = 4'b0000;
  endtask

  // Reset at the very edge a preemption would happen: no pulse, all cleared.
  task automatic test_reset_mid_grant();
    do_reset();
    request = 4'b0100;
    tick();
    request = 4'b0000;
    tick();
    request = 4'b0110;
    tick();
    n_cmp++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL midreset_setup: grant=%b id=%0d, required 0010/1", grant, grant_id);
    end
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || grant_id !== 2'd0 || preempted !== 1'b0 || grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: grant=%b id=%0d pre=%b valid=%b, required 0000/0/0/0",
               grant, grant_id, preempted, grant_valid);
    end
    n_cmp++;
    if (dbg_prio_ptr !== 2'd0 || dbg_state !== 1'b0 || dbg_hold_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_internal: ptr=%0d state=%b hold=%0d, required 0/0/0",
               dbg_prio_ptr, dbg_state, dbg_hold_cnt);
    end
    reset   = 1'b1;
    request = 4'b1000;
    tick();
    n_cmp++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      n_fail++;
      $display("FAIL midreset_regrant: grant=%b id=%0d, required 1000/3", grant, grant_id);
    end
    request = 4'b0000;
    tick();
    n_cmp++;
    if (dbg_prio_ptr !== 2'd0 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL ptr_wrap: ptr=%0d grant=%b, required 0/0000", dbg_prio_ptr, grant);
    end
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    request   = '0;
    request_f = '0;
    test_reset();
    test_preempt();
    test_single_hold();
    test_round_robin();
    test_fixed_prio();
    test_enable();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
